// File: rtl/he_lb_csr_responder.sv
// ----------------------------------------------------------------------------
// he_lb_csr_responder
//   MMIO CSR responder for the host-exerciser loopback (HE-LB) register map
//   (byte offsets 0x000-0x180). Host read/write requests are decoded against
//   a flat space of 32-bit words: 64-bit accesses cover an aligned word pair,
//   and 32-bit accesses reach a single word. The block holds the RW control
//   registers and returns the RO identity, status and INFO0 words.
//
//   Ports
//     clk, rst                 single clock, synchronous active-high reset
//     req_*                    MMIO request channel (valid/ready, write, dw,
//                              byte addr, write data, read tag)
//     rsp_*                    read response channel (valid/ready, data, tag)
//     err_misalign             1-cycle pulse on a misaligned access
//     ctl_run_n/start/stop     engine control derived from CTL (0x138)
//     dsm_base, src_addr, dst_addr, num_lines, cfg, stride, inact_thresh
//                              register values driven to the HE-LB engines
//     status0_in/status1_in/error_in
//                              engine status, sampled when the read decodes
// ----------------------------------------------------------------------------
module he_lb_csr_responder #(
    parameter logic [63:0] DFH_VALUE        = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L         = 64'h0,
    parameter logic [63:0] AFU_ID_H         = 64'h0,
    parameter logic [15:0] CLK_MHZ          = 16'd250,
    parameter logic [7:0]  API_VERSION      = 8'd1,
    parameter logic        ATOMICS          = 1'b0,
    parameter logic [1:0]  BUS_WIDTH_SHIFT  = 2'd1,
    parameter logic [4:0]  LMEM_WIDTH_SHIFT = 5'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_dw,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [9:0]  req_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [9:0]  rsp_tag,
    output logic        err_misalign,
    output logic        ctl_run_n,
    output logic        ctl_start,
    output logic        ctl_stop,
    output logic [63:0] dsm_base,
    output logic [63:0] src_addr,
    output logic [63:0] dst_addr,
    output logic [19:0] num_lines,
    output logic [63:0] cfg,
    output logic [63:0] stride,
    output logic [31:0] inact_thresh,
    input  logic [63:0] status0_in,
    input  logic [63:0] status1_in,
    input  logic [63:0] error_in
);

    // Qword indices (byte offset >> 3) of every mapped location.
    localparam logic [12:0] Q_DFH      = 13'h000;
    localparam logic [12:0] Q_AFU_ID_L = 13'h001;
    localparam logic [12:0] Q_AFU_ID_H = 13'h002;
    localparam logic [12:0] Q_SCRATCH0 = 13'h020;
    localparam logic [12:0] Q_SCRATCH1 = 13'h021;
    localparam logic [12:0] Q_DSM      = 13'h022;
    localparam logic [12:0] Q_SRC      = 13'h024;
    localparam logic [12:0] Q_DST      = 13'h025;
    localparam logic [12:0] Q_NUMLINES = 13'h026;
    localparam logic [12:0] Q_CTL      = 13'h027;
    localparam logic [12:0] Q_CFG      = 13'h028;
    localparam logic [12:0] Q_INACT    = 13'h029;
    localparam logic [12:0] Q_INT0     = 13'h02A;
    localparam logic [12:0] Q_SWTEST   = 13'h02B;
    localparam logic [12:0] Q_STATUS0  = 13'h02C;
    localparam logic [12:0] Q_STATUS1  = 13'h02D;
    localparam logic [12:0] Q_ERROR    = 13'h02E;
    localparam logic [12:0] Q_STRIDE   = 13'h02F;
    localparam logic [12:0] Q_INFO0    = 13'h030;

    localparam logic [31:0] INFO0 = {LMEM_WIDTH_SHIFT, BUS_WIDTH_SHIFT, ATOMICS,
                                     API_VERSION, CLK_MHZ};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_DECODE = 2'd1,
        ST_RD_RSP    = 2'd2
    } state_t;

    state_t      state_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [63:0] rsp_data_r;
    logic [9:0]  rsp_tag_r;
    logic        err_misalign_r;
    logic [15:0] rd_addr_r;
    logic        rd_dw_r;
    logic [9:0]  rd_tag_r;

    logic [63:0] scratch0_r;
    logic [63:0] scratch1_r;
    logic [63:0] dsm_base_r;
    logic [63:0] src_addr_r;
    logic [63:0] dst_addr_r;
    logic [19:0] num_lines_r;
    logic        ctl_run_r;
    logic        ctl_start_r;
    logic        ctl_stop_r;
    logic [63:0] cfg_r;
    logic [31:0] inact_r;
    logic [31:0] int0_r;
    logic [63:0] swtest_r;
    logic [63:0] stride_r;

    logic        accept_s;
    logic        wr_accept_s;
    logic        rd_accept_s;
    logic        misalign_s;
    logic [12:0] wr_qaddr_s;
    logic        wr_lo_s;
    logic        wr_hi_s;
    logic [31:0] wr_lo_data_s;
    logic [31:0] wr_hi_data_s;
    logic        rd_misalign_s;
    logic [63:0] rd_qword_s;
    logic [63:0] rd_data_s;

    // Replace the enabled 32-bit halves of a stored qword.
    function automatic logic [63:0] merge_qword(input logic [63:0] old_q,
                                                input logic        lo_en,
                                                input logic        hi_en,
                                                input logic [31:0] lo_d,
                                                input logic [31:0] hi_d);
        return {(hi_en ? hi_d : old_q[63:32]), (lo_en ? lo_d : old_q[31:0])};
    endfunction

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_tag      = rsp_tag_r;
    assign err_misalign = err_misalign_r;
    assign ctl_run_n    = ctl_run_r;
    assign ctl_start    = ctl_start_r;
    assign ctl_stop     = ctl_stop_r;
    assign dsm_base     = dsm_base_r;
    assign src_addr     = src_addr_r;
    assign dst_addr     = dst_addr_r;
    assign num_lines    = num_lines_r;
    assign cfg          = cfg_r;
    assign stride       = stride_r;
    assign inact_thresh = inact_r;

    // Request decode: handshake, alignment and which word halves a write hits.
    always_comb begin
        accept_s     = req_valid & req_ready_r;
        wr_accept_s  = accept_s & req_write;
        rd_accept_s  = accept_s & ~req_write;
        misalign_s   = req_dw ? (req_addr[1:0] != 2'b00) : (req_addr[2:0] != 3'b000);
        wr_qaddr_s   = req_addr[15:3];
        wr_lo_data_s = req_wdata[31:0];
        if (req_dw) begin
            // A 32-bit write lands on one word; addr[2] picks the half.
            wr_lo_s      = ~req_addr[2];
            wr_hi_s      = req_addr[2];
            wr_hi_data_s = req_wdata[31:0];
        end else begin
            wr_lo_s      = 1'b1;
            wr_hi_s      = 1'b1;
            wr_hi_data_s = req_wdata[63:32];
        end
    end

    // RW register file and the CTL start/stop pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch0_r  <= 64'h0;
            scratch1_r  <= 64'h0;
            dsm_base_r  <= 64'h0;
            src_addr_r  <= 64'h0;
            dst_addr_r  <= 64'h0;
            num_lines_r <= 20'h0;
            ctl_run_r   <= 1'b0;
            ctl_start_r <= 1'b0;
            ctl_stop_r  <= 1'b0;
            cfg_r       <= 64'h0;
            inact_r     <= 32'h0;
            int0_r      <= 32'h0;
            swtest_r    <= 64'h0;
            stride_r    <= 64'h0;
        end else begin
            ctl_start_r <= 1'b0;
            ctl_stop_r  <= 1'b0;
            if (wr_accept_s && !misalign_s) begin
                case (wr_qaddr_s)
                    Q_SCRATCH0: scratch0_r <= merge_qword(scratch0_r, wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_SCRATCH1: scratch1_r <= merge_qword(scratch1_r, wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_DSM:      dsm_base_r <= merge_qword(dsm_base_r, wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_SRC:      src_addr_r <= merge_qword(src_addr_r, wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_DST:      dst_addr_r <= merge_qword(dst_addr_r, wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_CFG:      cfg_r      <= merge_qword(cfg_r,      wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_SWTEST:   swtest_r   <= merge_qword(swtest_r,   wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_STRIDE:   stride_r   <= merge_qword(stride_r,   wr_lo_s, wr_hi_s, wr_lo_data_s, wr_hi_data_s);
                    Q_NUMLINES: if (wr_lo_s) num_lines_r <= wr_lo_data_s[19:0];
                    Q_INACT:    if (wr_lo_s) inact_r <= wr_lo_data_s;
                    Q_INT0:     if (wr_lo_s) int0_r <= wr_lo_data_s;
                    Q_CTL: begin
                        if (wr_lo_s) begin
                            // Start needs run_n set by this same write.
                            ctl_run_r   <= wr_lo_data_s[0];
                            ctl_start_r <= wr_lo_data_s[0] & wr_lo_data_s[1];
                            ctl_stop_r  <= wr_lo_data_s[2];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data mux for the latched read address.
    always_comb begin
        rd_misalign_s = rd_dw_r ? (rd_addr_r[1:0] != 2'b00) : (rd_addr_r[2:0] != 3'b000);
        case (rd_addr_r[15:3])
            Q_DFH:      rd_qword_s = DFH_VALUE;
            Q_AFU_ID_L: rd_qword_s = AFU_ID_L;
            Q_AFU_ID_H: rd_qword_s = AFU_ID_H;
            Q_SCRATCH0: rd_qword_s = scratch0_r;
            Q_SCRATCH1: rd_qword_s = scratch1_r;
            Q_DSM:      rd_qword_s = dsm_base_r;
            Q_SRC:      rd_qword_s = src_addr_r;
            Q_DST:      rd_qword_s = dst_addr_r;
            Q_NUMLINES: rd_qword_s = {44'h0, num_lines_r};
            Q_CTL:      rd_qword_s = {63'h0, ctl_run_r};
            Q_CFG:      rd_qword_s = cfg_r;
            Q_INACT:    rd_qword_s = {32'h0, inact_r};
            Q_INT0:     rd_qword_s = {32'h0, int0_r};
            Q_SWTEST:   rd_qword_s = swtest_r;
            Q_STATUS0:  rd_qword_s = status0_in;
            Q_STATUS1:  rd_qword_s = status1_in;
            Q_ERROR:    rd_qword_s = error_in;
            Q_STRIDE:   rd_qword_s = stride_r;
            Q_INFO0:    rd_qword_s = {32'h0, INFO0};
            default:    rd_qword_s = 64'h0;
        endcase
        if (rd_misalign_s) begin
            rd_data_s = 64'h0;
        end else if (rd_dw_r) begin
            rd_data_s = {32'h0, (rd_addr_r[2] ? rd_qword_s[63:32] : rd_qword_s[31:0])};
        end else begin
            rd_data_s = rd_qword_s;
        end
    end

    // Read FSM with registered handshake, response and misalign pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            req_ready_r    <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_data_r     <= 64'h0;
            rsp_tag_r      <= 10'h0;
            err_misalign_r <= 1'b0;
            rd_addr_r      <= 16'h0;
            rd_dw_r        <= 1'b0;
            rd_tag_r       <= 10'h0;
        end else begin
            err_misalign_r <= accept_s & misalign_s;
            case (state_r)
                ST_IDLE: begin
                    if (rd_accept_s) begin
                        rd_addr_r   <= req_addr;
                        rd_dw_r     <= req_dw;
                        rd_tag_r    <= req_tag;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_RD_DECODE;
                    end
                end
                ST_RD_DECODE: begin
                    rsp_data_r  <= rd_data_s;
                    rsp_tag_r   <= rd_tag_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RD_RSP;
                end
                ST_RD_RSP: begin
                    // Data and tag stay put until the host takes them.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_he_lb_csr_responder.sv
// ----------------------------------------------------------------------------
// tb_he_lb_csr_responder
//   Self-checking bench. A word-addressed reference model (array of 32-bit
//   words plus per-word writable masks and RO constants) predicts every read
//   and every control output; directed scenarios and a randomized sequence
//   drive the DUT through it.
// ----------------------------------------------------------------------------
module tb_he_lb_csr_responder;

    localparam logic [63:0] DFH       = 64'h1000_0000_0000_1000;
    localparam logic [63:0] INFO0_EXP = 64'h0000_0000_2201_00FA;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_dw;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [9:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [9:0]  rsp_tag;
    logic        err_misalign;
    logic        ctl_run_n;
    logic        ctl_start;
    logic        ctl_stop;
    logic [63:0] dsm_base;
    logic [63:0] src_addr;
    logic [63:0] dst_addr;
    logic [19:0] num_lines;
    logic [63:0] cfg;
    logic [63:0] stride;
    logic [31:0] inact_thresh;
    logic [63:0] status0_in;
    logic [63:0] status1_in;
    logic [63:0] error_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: writable word storage for offsets 0x000-0x1FC.
    logic [31:0] mem [0:127];

    he_lb_csr_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_dw(req_dw), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .err_misalign(err_misalign), .ctl_run_n(ctl_run_n), .ctl_start(ctl_start),
        .ctl_stop(ctl_stop), .dsm_base(dsm_base), .src_addr(src_addr), .dst_addr(dst_addr),
        .num_lines(num_lines), .cfg(cfg), .stride(stride), .inact_thresh(inact_thresh),
        .status0_in(status0_in), .status1_in(status1_in), .error_in(error_in)
    );

    always #5 clk = ~clk;

    // Bits of each 32-bit word that hold written data.
    function automatic logic [31:0] wmask(input logic [15:0] a);
        case (a)
            16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0110, 16'h0114,
            16'h0120, 16'h0124, 16'h0128, 16'h012C, 16'h0140, 16'h0144,
            16'h0148, 16'h0150, 16'h0158, 16'h015C, 16'h0178, 16'h017C:
                return 32'hFFFF_FFFF;
            16'h0130: return 32'h000F_FFFF;
            16'h0138: return 32'h0000_0001;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ro_word(input logic [15:0] a);
        case (a)
            16'h0000: return DFH[31:0];
            16'h0004: return DFH[63:32];
            16'h0160: return status0_in[31:0];
            16'h0164: return status0_in[63:32];
            16'h0168: return status1_in[31:0];
            16'h016C: return status1_in[63:32];
            16'h0170: return error_in[31:0];
            16'h0174: return error_in[63:32];
            16'h0180: return INFO0_EXP[31:0];
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        return ro_word(a) | (mem[a[8:2]] & wmask(a));
    endfunction

    function automatic logic is_mis(input logic [15:0] a, input logic dw);
        return dw ? (a[1:0] != 2'b00) : (a[2:0] != 3'b000);
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] a, input logic dw);
        if (is_mis(a, dw)) return 64'h0;
        if (dw) return {32'h0, rd_word(a)};
        return {rd_word(a + 16'd4), rd_word(a)};
    endfunction

    task automatic wr_word(input logic [15:0] a, input logic [31:0] d);
        if (wmask(a) != 32'h0) mem[a[8:2]] = d & wmask(a);
    endtask

    task automatic model_write(input logic [15:0] a, input logic dw, input logic [63:0] d);
        if (!is_mis(a, dw)) begin
            wr_word(a, d[31:0]);
            if (!dw) wr_word(a + 16'd4, d[63:32]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic dw, input logic [63:0] d);
        logic exp_start;
        logic exp_stop;
        exp_start = !is_mis(a, dw) && (a == 16'h0138) && (d[1:0] == 2'b11);
        exp_stop  = !is_mis(a, dw) && (a == 16'h0138) && d[2];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_dw = dw; req_addr = a; req_wdata = d;
        req_tag = 10'($urandom_range(0, 1023));
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        model_write(a, dw, d);
        @(negedge clk);
        n_cmp++;
        if (err_misalign !== is_mis(a, dw)) begin
            n_fail++; $display("FAIL wr_misalign @%h: got %b want %b", a, err_misalign, is_mis(a, dw));
        end
        n_cmp++;
        if (ctl_start !== exp_start) begin n_fail++; $display("FAIL wr_start @%h: got %b want %b", a, ctl_start, exp_start); end
        n_cmp++;
        if (ctl_stop !== exp_stop) begin n_fail++; $display("FAIL wr_stop @%h: got %b want %b", a, ctl_stop, exp_stop); end
    endtask

    task automatic do_read(input logic [15:0] a, input logic dw, input logic [9:0] tag, input int hold);
        logic [63:0] exp;
        exp = model_read(a, dw);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_dw = dw; req_addr = a; req_tag = tag;
        req_wdata = {$urandom, $urandom};
        rsp_ready = (hold == 0);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid @%h: got %b want 0", a, rsp_valid); end
        n_cmp++;
        if (err_misalign !== is_mis(a, dw)) begin
            n_fail++; $display("FAIL rd_misalign @%h: got %b want %b", a, err_misalign, is_mis(a, dw));
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid_n2 @%h: got %b want 1", a, rsp_valid); end
        n_cmp++;
        if (rsp_data !== exp) begin n_fail++; $display("FAIL rd_data @%h dw=%b: got %h want %h", a, dw, rsp_data, exp); end
        n_cmp++;
        if (rsp_tag !== tag) begin n_fail++; $display("FAIL rd_tag @%h: got %h want %h", a, rsp_tag, tag); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== exp || rsp_tag !== tag) begin
                n_fail++;
                $display("FAIL rd_hold%0d: valid=%b ready=%b data=%h tag=%h want 1/0/%h/%h",
                         i, rsp_valid, req_ready, rsp_data, rsp_tag, exp, tag);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic check_outputs();
        n_cmp++;
        if (dsm_base !== {rd_word(16'h0114), rd_word(16'h0110)}) begin n_fail++; $display("FAIL out_dsm: got %h", dsm_base); end
        n_cmp++;
        if (src_addr !== {rd_word(16'h0124), rd_word(16'h0120)}) begin n_fail++; $display("FAIL out_src: got %h", src_addr); end
        n_cmp++;
        if (dst_addr !== {rd_word(16'h012C), rd_word(16'h0128)}) begin n_fail++; $display("FAIL out_dst: got %h", dst_addr); end
        n_cmp++;
        if (num_lines !== rd_word(16'h0130)[19:0]) begin n_fail++; $display("FAIL out_lines: got %h", num_lines); end
        n_cmp++;
        if (cfg !== {rd_word(16'h0144), rd_word(16'h0140)}) begin n_fail++; $display("FAIL out_cfg: got %h", cfg); end
        n_cmp++;
        if (stride !== {rd_word(16'h017C), rd_word(16'h0178)}) begin n_fail++; $display("FAIL out_stride: got %h", stride); end
        n_cmp++;
        if (inact_thresh !== rd_word(16'h0148)) begin n_fail++; $display("FAIL out_inact: got %h", inact_thresh); end
        n_cmp++;
        if (ctl_run_n !== rd_word(16'h0138)[0]) begin n_fail++; $display("FAIL out_run_n: got %b", ctl_run_n); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 64'h0 || rsp_tag !== 10'h0) begin
            n_fail++; $display("FAIL reset_chan: ready=%b valid=%b data=%h tag=%h", req_ready, rsp_valid, rsp_data, rsp_tag);
        end
        n_cmp++;
        if (err_misalign !== 1'b0 || ctl_start !== 1'b0 || ctl_stop !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: err=%b start=%b stop=%b", err_misalign, ctl_start, ctl_stop);
        end
        check_outputs();
    endtask

    task automatic test_identity();
        do_read(16'h0180, 1'b0, 10'd5, 0);
        n_cmp++;
        if (model_read(16'h0180, 1'b0) !== rsp_data) begin n_fail++; $display("FAIL info0_hold: got %h", rsp_data); end
        do_read(16'h0000, 1'b0, 10'd6, 0);
        do_read(16'h0004, 1'b1, 10'd7, 0);
        do_read(16'h0180, 1'b1, 10'd8, 0);
    endtask

    task automatic test_scratch();
        do_write(16'h0104, 1'b1, 64'h1234_5678_DEAD_BEEF);
        do_read(16'h0100, 1'b0, 10'd9, 0);
        n_cmp++;
        if (rsp_data !== 64'hDEAD_BEEF_0000_0000) begin
            n_fail++; $display("FAIL scratch_const: got %h want DEADBEEF00000000", rsp_data);
        end
        do_write(16'h0108, 1'b0, 64'hCAFE_F00D_0123_4567);
        do_read(16'h010C, 1'b1, 10'd10, 0);
        do_write(16'h0130, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(16'h0130, 1'b0, 10'd11, 0);
        check_outputs();
    endtask

    task automatic test_ctl();
        do_write(16'h0138, 1'b0, 64'h3);
        n_cmp++;
        if (ctl_run_n !== 1'b1) begin n_fail++; $display("FAIL ctl_run_set: got %b want 1", ctl_run_n); end
        @(negedge clk);
        n_cmp++;
        if (ctl_start !== 1'b0) begin n_fail++; $display("FAIL ctl_start_width: got %b want 0", ctl_start); end
        do_write(16'h0138, 1'b0, 64'h0);
        do_write(16'h0138, 1'b0, 64'h2);
        n_cmp++;
        if (ctl_run_n !== 1'b0) begin n_fail++; $display("FAIL ctl_run_clr: got %b want 0", ctl_run_n); end
        do_write(16'h0138, 1'b1, 64'h4);
        @(negedge clk);
        n_cmp++;
        if (ctl_stop !== 1'b0) begin n_fail++; $display("FAIL ctl_stop_width: got %b want 0", ctl_stop); end
        do_write(16'h0138, 1'b1, 64'h7);
        do_read(16'h0138, 1'b0, 10'd12, 0);
        check_outputs();
    endtask

    task automatic test_backpressure();
        status0_in = {$urandom, $urandom};
        do_read(16'h0160, 1'b0, 10'h2A5, 5);
        do_read(16'h0164, 1'b1, 10'h15A, 3);
    endtask

    task automatic test_misalign();
        do_write(16'h0108, 1'b0, 64'h1111_2222_3333_4444);
        do_write(16'h010C, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(16'h0108, 1'b0, 10'd13, 0);
        do_write(16'h0101, 1'b1, 64'hFFFF_FFFF);
        do_read(16'h0102, 1'b1, 10'd14, 0);
        do_read(16'h0104, 1'b0, 10'd15, 0);
        do_read(16'h0200, 1'b0, 10'd16, 0);
        n_cmp++;
        if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", rsp_data); end
        do_write(16'h0160, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(16'h0118, 1'b0, 10'd17, 0);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        dw;
        int          r;
        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(0, 9));
            dw = 1'($urandom_range(0, 1));
            if (r < 7)       a = 16'(32'h100 + $urandom_range(0, 31) * 4);
            else if (r == 7) a = 16'($urandom_range(0, 32'h1FF));
            else             a = 16'($urandom_range(0, 32'h30) * 8);
            if (!dw && r < 7 && $urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, dw, {$urandom, $urandom});
                check_outputs();
            end else begin
                status0_in = {$urandom, $urandom};
                status1_in = {$urandom, $urandom};
                error_in   = {$urandom, $urandom};
                do_read(a, dw, 10'($urandom_range(0, 1023)), int'($urandom_range(0, 2)));
            end
        end
    endtask

    task automatic test_reset_in_rsp();
        logic [15:0] rw_q [$] = '{16'h0100, 16'h0108, 16'h0110, 16'h0120, 16'h0128, 16'h0130,
                                  16'h0138, 16'h0140, 16'h0148, 16'h0150, 16'h0158, 16'h0178};
        foreach (rw_q[i]) do_write(rw_q[i], 1'b0, {$urandom | 32'h1, $urandom | 32'h1});
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_dw = 1'b0; req_addr = 16'h0108; req_tag = 10'd99;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_rsp_pre: got %b want 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_drop: got %b want 0", rsp_valid); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_rsp_after: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        check_outputs();
        foreach (rw_q[i]) do_read(rw_q[i], 1'b0, 10'(i), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dw = 1'b0; req_addr = 16'h0;
        req_wdata = 64'h0; req_tag = 10'h0; rsp_ready = 1'b1;
        status0_in = 64'h0123_4567_89AB_CDEF; status1_in = 64'hFEDC_BA98_7654_3210;
        error_in = 64'h0000_0000_0000_00E1;
        model_clear();
        test_reset();
        test_identity();
        test_scratch();
        test_ctl();
        test_backpressure();
        test_misalign();
        test_random();
        test_reset_in_rsp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
